// File: rtl/tri_bank_ctrl.sv
// tri_bank_ctrl: responder for one triple-buffer bank. It accepts a level-sampled,
// active-low request and runs one SETUP / ACCESS x WAIT_CYCLES / HOLD strobe
// sequence on an asynchronous SRAM. All outputs come straight from flops.
// Optional feature macro: TRI_BANK_BACK2BACK_EN. When defined, ready is high in
// HOLD and a request seen in HOLD is accepted directly, skipping the IDLE cycle.
module tri_bank_ctrl #(
   parameter int addr_bus_size = 16,
   parameter int data_bus_size = 16,
   parameter int WAIT_CYCLES   = 2    // ACCESS length, 1..15
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [addr_bus_size-1:0] addr,
   input  logic [data_bus_size-1:0] data_in,
   input  logic                     start,
   input  logic                     rw,
   output logic                     ready,
   output logic [data_bus_size-1:0] data_out,
   output logic [addr_bus_size-1:0] sram_addr,
   output logic [data_bus_size-1:0] sram_dq_o,
   input  logic [data_bus_size-1:0] sram_dq_i,
   output logic                     sram_dq_oe,
   output logic                     sram_ce_n,
   output logic                     sram_oe_n,
   output logic                     sram_we_n
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

   // wait_cnt is 4 bits because WAIT_CYCLES never exceeds 15
   localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

   state_t     state, state_nxt;
   logic [3:0] wait_cnt, cnt_nxt;
   logic       rw_q;
   logic       accept;
   logic       capture;
   logic       rw_nxt;
   logic       ready_nxt, ce_n_nxt, oe_n_nxt, we_n_nxt, dq_oe_nxt;

   // Next-state logic; strobe values are derived from the state being entered
   // so that every SRAM pin is driven by a flop.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = wait_cnt;
      accept    = 1'b0;
      unique case (state)
         IDLE: begin
            if (!start) begin
               accept    = 1'b1;
               state_nxt = SETUP;
            end
         end
         SETUP: begin
            state_nxt = ACCESS;
            cnt_nxt   = 4'd0;
         end
         ACCESS: begin
            if (wait_cnt == LAST_CNT) state_nxt = HOLD;
            else                      cnt_nxt   = wait_cnt + 4'd1;
         end
         HOLD: begin
`ifdef TRI_BANK_BACK2BACK_EN
            if (!start) begin
               accept    = 1'b1;
               state_nxt = SETUP;
            end else begin
               state_nxt = IDLE;
            end
`else
            state_nxt = IDLE;
`endif
         end
         default: state_nxt = IDLE;
      endcase

      // direction of the access that will be running next cycle
      rw_nxt    = accept ? rw : rw_q;
      ce_n_nxt  = (state_nxt == IDLE);
      oe_n_nxt  = !(rw_nxt && (state_nxt == SETUP || state_nxt == ACCESS));
      we_n_nxt  = !(!rw_nxt && state_nxt == ACCESS);
      dq_oe_nxt = !rw_nxt && (state_nxt != IDLE);
`ifdef TRI_BANK_BACK2BACK_EN
      ready_nxt = (state_nxt == IDLE) || (state_nxt == HOLD);
`else
      ready_nxt = (state_nxt == IDLE);
`endif
      // read data is sampled at the edge that leaves the last ACCESS cycle
      capture   = (state == ACCESS) && (wait_cnt == LAST_CNT) && rw_q;
   end

   // State, request latches and registered outputs; reset drops any access.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wait_cnt   <= 4'd0;
         rw_q       <= 1'b0;
         ready      <= 1'b1;
         data_out   <= '0;
         sram_addr  <= '0;
         sram_dq_o  <= '0;
         sram_dq_oe <= 1'b0;
         sram_ce_n  <= 1'b1;
         sram_oe_n  <= 1'b1;
         sram_we_n  <= 1'b1;
      end else begin
         state      <= state_nxt;
         wait_cnt   <= cnt_nxt;
         ready      <= ready_nxt;
         sram_dq_oe <= dq_oe_nxt;
         sram_ce_n  <= ce_n_nxt;
         sram_oe_n  <= oe_n_nxt;
         sram_we_n  <= we_n_nxt;
         if (accept) begin
            rw_q      <= rw;
            sram_addr <= addr;
            sram_dq_o <= data_in;
         end
         if (capture) data_out <= sram_dq_i;
      end
   end

endmodule

// File: tb/tb_tri_bank_ctrl.sv
// Bench for tri_bank_ctrl: directed reset/abort/latency cases, then random
// traffic. The driver pushes expected completions into a queue; a separate
// monitor pops one at every rising edge of ready and checks it.
module tb_tri_bank_ctrl;
   localparam int W = 2;
`ifdef TRI_BANK_BACK2BACK_EN
   localparam int BUSY = W + 1;
`else
   localparam int BUSY = W + 2;
`endif

   logic        clk = 1'b0;
   logic        rst, start, rw, ready;
   logic [15:0] addr, data_in, data_out, sram_addr, sram_dq_o, sram_dq_i;
   logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;

   tri_bank_ctrl #(.addr_bus_size(16), .data_bus_size(16), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .addr(addr), .data_in(data_in), .start(start), .rw(rw),
      .ready(ready), .data_out(data_out), .sram_addr(sram_addr), .sram_dq_o(sram_dq_o),
      .sram_dq_i(sram_dq_i), .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
      .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] init_val(input int i);
      return 16'(32'hA500 + i * 32'h0123);
   endfunction

   // SRAM model: 8 words, indexed by low address bits; writes land while we_n low
   logic [15:0] sram_mem [8];
   bit          mem_reinit = 1'b1;
   assign sram_dq_i = sram_oe_n ? 16'hDEAD : sram_mem[sram_addr[2:0]];
   always @(negedge clk) begin
      if (mem_reinit) begin
         for (int i = 0; i < 8; i++) sram_mem[i] = init_val(i);
      end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
         sram_mem[sram_addr[2:0]] = sram_dq_o;
      end
   end

   // reference: what memory should hold and what data_out should show
   logic [15:0] ref_mem [8];
   logic [15:0] last_rd;

   typedef struct {
      logic        rd;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp_dout;
   } exp_t;
   exp_t sb_q[$];

   // monitor: per-access strobe accounting, checked when ready rises
   bit run = 1'b0;
   bit prev_ready = 1'b1;
   int busy_c = 0, we_c = 0, oe_c = 0, ce_c = 0, dq_c = 0;
   always @(negedge clk) begin
      if (run) begin
         if (!ready) begin
            busy_c++;
            if (!sram_we_n) we_c++;
            if (!sram_oe_n) oe_c++;
            if (!sram_ce_n) ce_c++;
            if (sram_dq_oe) dq_c++;
         end else if (!prev_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_completion actual=1 expected=0");
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("data_out", 32'(data_out), 32'(e.exp_dout));
               chk("sram_addr", 32'(sram_addr), 32'(e.addr));
               if (!e.rd) chk("sram_dq_o", 32'(sram_dq_o), 32'(e.wdata));
               chk("busy_cycles", busy_c, BUSY);
               chk("we_low_cycles", we_c, e.rd ? 0 : W);
               chk("oe_low_cycles", oe_c, e.rd ? W + 1 : 0);
               chk("ce_low_cycles", ce_c, BUSY);
               chk("dq_oe_cycles", dq_c, e.rd ? 0 : BUSY);
            end
            busy_c = 0; we_c = 0; oe_c = 0; ce_c = 0; dq_c = 0;
         end
         prev_ready = ready;
      end
   end

   // one directed access with a one-cycle start pulse; inputs scrambled while busy
   task automatic do_op(input logic rd, input logic [15:0] a, input logic [15:0] d,
                        output int lat);
      @(posedge clk); #2;
      addr = a; data_in = d; rw = rd; start = 1'b0;
      @(posedge clk); #2;
      start = 1'b1; addr = ~a; data_in = ~d; rw = ~rd;
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ready) break;
         lat++;
      end
      if (!rd) ref_mem[a[2:0]] = d;
   endtask

   initial begin
      int lat;
      rst = 1'b1; start = 1'b1; rw = 1'b0; addr = '0; data_in = '0;
      for (int i = 0; i < 8; i++) ref_mem[i] = init_val(i);
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      mem_reinit = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(ready), 1);
      chk("rst_data_out", 32'(data_out), 0);
      chk("rst_sram_addr", 32'(sram_addr), 0);
      chk("rst_sram_dq_o", 32'(sram_dq_o), 0);
      chk("rst_dq_oe", 32'(sram_dq_oe), 0);
      chk("rst_ce_n", 32'(sram_ce_n), 1);
      chk("rst_oe_n", 32'(sram_oe_n), 1);
      chk("rst_we_n", 32'(sram_we_n), 1);

      // plain read of an initialised word
      do_op(1'b1, 16'h0003, 16'h0000, lat);
      chk("rd_latency", lat, BUSY);
      chk("rd_data", 32'(data_out), 32'(init_val(3)));
      chk("rd_addr_stable", 32'(sram_addr), 32'h0003);

      // write aborted by reset in its first ACCESS cycle
      @(posedge clk); #2;
      addr = 16'h0002; data_in = 16'hBEEF; rw = 1'b0; start = 1'b0;
      @(posedge clk); #2 start = 1'b1;
      @(posedge clk); #2 rst = 1'b1;
      @(posedge clk); #2 rst = 1'b0;
      @(negedge clk);
      chk("abort_ready", 32'(ready), 1);
      chk("abort_we_n", 32'(sram_we_n), 1);
      chk("abort_ce_n", 32'(sram_ce_n), 1);
      chk("abort_dq_oe", 32'(sram_dq_oe), 0);
      chk("abort_data_out", 32'(data_out), 0);
      repeat (3) @(negedge clk);
      chk("abort_no_restart", 32'(ready), 1);
      mem_reinit = 1'b1;
      @(negedge clk);
      mem_reinit = 1'b0;

      // write, read back, then a write that must not disturb data_out
      do_op(1'b0, 16'h0012, 16'hBEEF, lat);
      chk("wr_latency", lat, BUSY);
      chk("wr_addr", 32'(sram_addr), 32'h0012);
      chk("wr_data_latched", 32'(sram_dq_o), 32'hBEEF);
      chk("wr_keeps_dout", 32'(data_out), 0);
      do_op(1'b1, 16'h0012, 16'h0000, lat);
      chk("rb_data", 32'(data_out), 32'hBEEF);
      do_op(1'b0, 16'h0012, 16'h1234, lat);
      chk("wr2_keeps_dout", 32'(data_out), 32'hBEEF);
      last_rd = 16'hBEEF;

      // random traffic: start held low ~70% of cycles, inputs churn every cycle
      @(negedge clk);
      prev_ready = 1'b1;
      run = 1'b1;
      for (int c = 0; c < 500; c++) begin
         @(posedge clk); #2;
         addr    = {13'($urandom), 3'($urandom)};
         data_in = 16'($urandom);
         rw      = 1'($urandom);
         start   = ($urandom_range(0, 9) < 3);
         if (ready && !start) begin
            if (rw) begin
               last_rd = ref_mem[addr[2:0]];
               sb_q.push_back('{1'b1, addr, data_in, last_rd});
            end else begin
               ref_mem[addr[2:0]] = data_in;
               sb_q.push_back('{1'b0, addr, data_in, last_rd});
            end
         end
      end
      @(posedge clk); #2 start = 1'b1;

      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (sb_q.size() == 0 && ready) break;
      end
      chk("drain_pending", sb_q.size(), 0);
      repeat (2) @(negedge clk);
      chk("final_idle_ce_n", 32'(sram_ce_n), 1);
      chk("final_dout", 32'(data_out), 32'(last_rd));

      $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
      $finish;
   end

endmodule
